axis_rd_data: RTL and testbench

//  Read-data half of an AXI4 master-to-AXI-Stream bridge: accepts wide AXI R-channel beats, buffers

---
 rtl/axis_rd_data_pkg.sv | 21 ++
 rtl/axis_rd_data_if.sv | 31 +++
 rtl/axis_rd_fifo.sv | 47 ++++
 rtl/axis_rd_data.sv | 117 +++++++++++
 tb/tb_axis_rd_data.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_rd_data_pkg.sv
// rtl/axis_rd_data_pkg.sv - shared types and default geometry for the AXI read-data to stream bridge
package axis_rd_data_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int DEF_BUF_AWIDTH     = 4;
  localparam int DEF_CFG_DWIDTH     = 32;
  localparam int DEF_AXI_DATA_WIDTH = 256;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int RATIO              = DEF_AXI_DATA_WIDTH / DEF_DATA_WIDTH;
  localparam int RATIO_W            = (RATIO > 1) ? $clog2(RATIO) : 1;

  // A single-word beat still needs a one-bit index so the serialiser logic stays uniform.
  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/axis_rd_data_if.sv
// rtl/axis_rd_data_if.sv - config, AXI R-channel and output stream bundle of the bridge
interface axis_rd_data_if
  import axis_rd_data_pkg::*;
#(
  parameter int CFG_DWIDTH     = DEF_CFG_DWIDTH,
  parameter int AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH
);

  logic [CFG_DWIDTH-1:0]     cfg_length;
  logic                      cfg_val;
  logic                      cfg_rdy;
  logic [AXI_DATA_WIDTH-1:0] axi_rdata;
  logic                      axi_rlast;
  logic                      axi_rvalid;
  logic                      axi_rready;
  logic [DATA_WIDTH-1:0]     data;
  logic                      valid;
  logic                      ready;

  modport slave (
    input  cfg_length, cfg_val, axi_rdata, axi_rlast, axi_rvalid, ready,
    output cfg_rdy, axi_rready, data, valid
  );

  modport master (
    output cfg_length, cfg_val, axi_rdata, axi_rlast, axi_rvalid, ready,
    input  cfg_rdy, axi_rready, data, valid
  );

endinterface

// File: rtl/axis_rd_fifo.sv
// rtl/axis_rd_fifo.sv - first-word-fall-through beat FIFO with full/empty flags
module axis_rd_fifo
  import axis_rd_data_pkg::*;
#(
  parameter int WIDTH  = DEF_AXI_DATA_WIDTH,
  parameter int AWIDTH = DEF_BUF_AWIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 2 ** AWIDTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AWIDTH:0]  wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AWIDTH] != rptr_q[AWIDTH]) &&
                   (wptr_q[AWIDTH-1:0] == rptr_q[AWIDTH-1:0]);
  assign rdata_o = mem[rptr_q[AWIDTH-1:0]];

  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AWIDTH+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AWIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AWIDTH-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/axis_rd_data.sv
// rtl/axis_rd_data.sv - buffers wide AXI read beats and serialises them into cfg_length stream words
module axis_rd_data
  import axis_rd_data_pkg::*;
#(
  parameter int BUF_AWIDTH     = DEF_BUF_AWIDTH,
  parameter int CFG_DWIDTH     = DEF_CFG_DWIDTH,
  parameter int AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  axis_rd_data_if.slave  bus
);

  localparam int            NWORDS   = AXI_DATA_WIDTH / DATA_WIDTH;
  localparam int            IW       = idx_width(NWORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  state_e                    state_q, state_d;
  logic [CFG_DWIDTH-1:0]     cnt_q, cnt_d;
  logic [AXI_DATA_WIDTH-1:0] beat_q, beat_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      hold_q, hold_d;

  logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [AXI_DATA_WIDTH-1:0] fifo_rdata;
  logic                      cfg_fire, word_fire, final_word;
  logic                      unused_rlast;
  logic [NWORDS-1:0][DATA_WIDTH-1:0] lanes;

  assign unused_rlast = bus.axi_rlast;
  assign lanes        = beat_q;

  assign bus.axi_rready = rst & ~fifo_full;
  assign fifo_push      = bus.axi_rvalid & bus.axi_rready;

  axis_rd_fifo #(
    .WIDTH  (AXI_DATA_WIDTH),
    .AWIDTH (BUF_AWIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (bus.axi_rdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cfg_fire   = bus.cfg_val & bus.cfg_rdy & (bus.cfg_length != '0);
  assign word_fire  = bus.valid & bus.ready;
  assign final_word = word_fire & (cnt_q == CFG_DWIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_fire)   state_d = ACTIVE;
      ACTIVE:  if (final_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cfg_rdy = rst & (state_q == IDLE);
    bus.valid   = (state_q == ACTIVE) & hold_q;
    bus.data    = ((state_q == ACTIVE) & hold_q) ? lanes[idx_q] : '0;
  end

  // The next beat is fetched on the same edge the last word of the current one leaves,
  // so a steady ready sees no bubble at beat boundaries.
  always_comb begin
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    fifo_pop = 1'b0;

    if (cfg_fire)       cnt_d = bus.cfg_length;
    else if (word_fire) cnt_d = cnt_q - CFG_DWIDTH'(1);

    if (state_q == ACTIVE) begin
      if (final_word) begin
        hold_d = 1'b0;
      end else if (!hold_q || (word_fire && idx_q == LAST_IDX)) begin
        hold_d = ~fifo_empty;
        if (!fifo_empty) begin
          beat_d   = fifo_rdata;
          idx_d    = '0;
          fifo_pop = 1'b1;
        end
      end else if (word_fire) begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      beat_q <= '0;
      idx_q  <= '0;
      hold_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      beat_q <= beat_d;
      idx_q  <= idx_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: tb/tb_axis_rd_data.sv
// tb/tb_axis_rd_data.sv - randomized scoreboard bench for axis_rd_data
module tb_axis_rd_data;

  localparam int DW = 32;
  localparam int AW = 256;
  localparam int CW = 32;
  localparam int R  = AW / DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axis_rd_data_if #(.CFG_DWIDTH(CW), .AXI_DATA_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axis_rd_data #(
    .BUF_AWIDTH     (4),
    .CFG_DWIDTH     (CW),
    .AXI_DATA_WIDTH (AW),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] drvq[$];
  logic [AW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  int            ready_mode = 0;
  bit            axi_gaps   = 1'b0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [AW-1:0] rand_beat();
    logic [AW-1:0] b;
    for (int k = 0; k < R; k++) b[k*DW +: DW] = $urandom;
    return b;
  endfunction

  function automatic void add_beat(input logic [AW-1:0] b);
    drvq.push_back(b);
    mq.push_back(b);
  endfunction

  // Reference: a transfer of len words walks whole beats in arrival order, LSW first;
  // whatever is left of the beat holding the last word is thrown away.
  function automatic void expect_transfer(input int len);
    int n = 0;
    logic [AW-1:0] b;
    while (n < len && mq.size() > 0) begin
      b = mq.pop_front();
      for (int k = 0; k < R && n < len; k++) begin
        exp_q.push_back(b[k*DW +: DW]);
        n++;
      end
    end
  endfunction

  task automatic send_cfg(input int len);
    int n = 0;
    @(posedge clk); #1;
    bus.cfg_val    = 1'b1;
    bus.cfg_length = CW'(len);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cfg_rdy && n < 200);
    chk("cfg_accept", AW'(bus.cfg_rdy), AW'(1));
    @(posedge clk); #1;
    bus.cfg_val = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (!bus.valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, AW'(bus.valid), AW'(1));
  endtask

  task automatic wait_axi_empty(input int budget, input string name);
    int n = 0;
    while (drvq.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, AW'(drvq.size()), AW'(0));
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && bus.cfg_rdy && drvq.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_left"}, AW'(exp_q.size()), AW'(0));
    chk({name, "_idle"}, AW'(bus.cfg_rdy), AW'(1));
  endtask

  initial begin : axi_drv
    bit hs;
    bus.axi_rvalid = 1'b0;
    bus.axi_rdata  = '0;
    bus.axi_rlast  = 1'b0;
    forever begin
      @(negedge clk);
      hs = bus.axi_rvalid && bus.axi_rready;
      @(posedge clk); #1;
      if (hs && drvq.size() > 0) void'(drvq.pop_front());
      if (drvq.size() > 0 && (!axi_gaps || bus.axi_rvalid || $urandom_range(0, 2) != 0)) begin
        bus.axi_rvalid = 1'b1;
        bus.axi_rdata  = drvq[0];
        bus.axi_rlast  = (drvq.size() == 1);
      end else begin
        bus.axi_rvalid = 1'b0;
      end
    end
  end

  initial begin : rdy_drv
    bus.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.ready = 1'b1;
        1:       bus.ready = ~bus.ready;
        2:       bus.ready = 1'($urandom_range(0, 1));
        default: bus.ready = 1'b0;
      endcase
    end
  end

  initial begin : mon
    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev       = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", AW'(bus.valid), AW'(1));
          chk("hold_data", AW'(bus.data), AW'(prev));
        end
        if (bus.valid && bus.ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_word actual=%0h required=none", bus.data);
          end else begin
            chk("word", AW'(bus.data), AW'(exp_q.pop_front()));
          end
        end
        stall_prev = bus.valid && !bus.ready;
        prev       = bus.data;
      end
    end
  end

  initial begin : main
    logic [AW-1:0] b1, b2;
    int lat, len;

    bus.cfg_val    = 1'b0;
    bus.cfg_length = '0;

    @(negedge clk);
    chk("rst_cfg_rdy", AW'(bus.cfg_rdy), AW'(0));
    chk("rst_axi_rready", AW'(bus.axi_rready), AW'(0));
    chk("rst_valid", AW'(bus.valid), AW'(0));
    chk("rst_data", AW'(bus.data), AW'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_cfg_rdy", AW'(bus.cfg_rdy), AW'(1));
    chk("rel_axi_rready", AW'(bus.axi_rready), AW'(1));

    // two known beats, ten words, back to back
    ready_mode = 0;
    axi_gaps   = 1'b0;
    for (int k = 0; k < R; k++) begin
      b1[k*DW +: DW] = DW'(k + 1);
      b2[k*DW +: DW] = DW'(k + 2);
    end
    add_beat(b1);
    add_beat(b2);
    wait_axi_empty(50, "t2_axi");
    repeat (2) @(negedge clk);
    expect_transfer(10);
    send_cfg(10);
    wait_valid(10, "t2_start");
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      chk("t2_back2back", AW'(bus.valid && bus.ready), AW'(1));
    end
    @(negedge clk);
    chk("t2_end_valid", AW'(bus.valid), AW'(0));
    chk("t2_end_cfg_rdy", AW'(bus.cfg_rdy), AW'(1));

    // beat arrival latency with an already-active transfer and empty FIFO
    send_cfg(8);
    repeat (2) @(negedge clk);
    add_beat(rand_beat());
    expect_transfer(8);
    wait_axi_empty(50, "lat_axi");
    lat = 0;
    while (!bus.valid && lat < 5) begin
      @(negedge clk);
      lat++;
    end
    chk("latency_le2", AW'(lat <= 2), AW'(1));
    wait_drain(100, "lat_drain");

    // toggling ready
    ready_mode = 1;
    axi_gaps   = 1'b1;
    add_beat(rand_beat());
    add_beat(rand_beat());
    expect_transfer(16);
    send_cfg(16);
    wait_drain(200, "t3");

    // fill FIFO while idle, then drain all 17 beats
    ready_mode = 0;
    axi_gaps   = 1'b0;
    for (int i = 0; i < 17; i++) add_beat(rand_beat());
    repeat (30) @(negedge clk);
    chk("t4_rready_low", AW'(bus.axi_rready), AW'(0));
    chk("t4_accepted16", AW'(drvq.size()), AW'(1));
    chk("t4_idle_valid", AW'(bus.valid), AW'(0));
    expect_transfer(136);
    ready_mode = 2;
    send_cfg(136);
    wait_drain(1500, "t4");

    // zero length ignored, cfg_val during ACTIVE ignored
    ready_mode = 0;
    add_beat(rand_beat());
    send_cfg(0);
    repeat (5) @(negedge clk);
    chk("t5_zero_valid", AW'(bus.valid), AW'(0));
    chk("t5_zero_idle", AW'(bus.cfg_rdy), AW'(1));
    ready_mode = 3;
    expect_transfer(8);
    send_cfg(8);
    repeat (3) @(negedge clk);
    chk("t5_active", AW'(bus.cfg_rdy), AW'(0));
    @(posedge clk); #1;
    bus.cfg_val    = 1'b1;
    bus.cfg_length = CW'(3);
    repeat (2) @(posedge clk);
    #1;
    bus.cfg_val = 1'b0;
    ready_mode  = 0;
    wait_drain(100, "t5");

    // short transfer leaves the second beat for the next one
    ready_mode = 2;
    add_beat(rand_beat());
    add_beat(rand_beat());
    wait_axi_empty(50, "t6_axi");
    expect_transfer(3);
    send_cfg(3);
    wait_drain(100, "t6a");
    expect_transfer(8);
    send_cfg(8);
    wait_drain(100, "t6b");

    // random transfers
    for (int t = 0; t < 20; t++) begin
      len        = $urandom_range(1, 40);
      ready_mode = $urandom_range(0, 2);
      axi_gaps   = 1'($urandom_range(0, 1));
      for (int i = 0; i < (len + R - 1) / R; i++) add_beat(rand_beat());
      expect_transfer(len);
      send_cfg(len);
      wait_drain(1000, "rand");
    end

    // asynchronous reset in the middle of a stalled transfer
    ready_mode = 3;
    axi_gaps   = 1'b0;
    for (int i = 0; i < 3; i++) add_beat(rand_beat());
    expect_transfer(24);
    send_cfg(24);
    wait_valid(20, "t1_valid_before");
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("t1_rst_valid", AW'(bus.valid), AW'(0));
    chk("t1_rst_cfg_rdy", AW'(bus.cfg_rdy), AW'(0));
    chk("t1_rst_axi_rready", AW'(bus.axi_rready), AW'(0));
    exp_q.delete();
    drvq.delete();
    mq.delete();
    bus.axi_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t1_rel_cfg_rdy", AW'(bus.cfg_rdy), AW'(1));
    chk("t1_rel_axi_rready", AW'(bus.axi_rready), AW'(1));
    chk("t1_rel_valid", AW'(bus.valid), AW'(0));
    ready_mode = 0;
    send_cfg(8);
    repeat (5) @(negedge clk);
    chk("t1_fifo_empty", AW'(bus.valid), AW'(0));
    add_beat(rand_beat());
    expect_transfer(8);
    wait_drain(100, "t1_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
